display_scan: RTL and testbench



---
 rtl/display_scan.sv | 139 +++++++++++++
 tb/tb_display_scan.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// ============================================================================
// Module   : display_scan
// Function : Time-multiplexed scan of six BCD digits (HH:MM:SS) onto a single
//            digit channel. It outputs the digit position, the digit code, a
//            one-hot digit enable and a blink request for the digit being edited.
//            At each frame start the digit bus is captured into a snapshot, so a
//            frame cannot show a mix of old and new time values.
// Options  : `define LEADING_ZERO_BLANK_EN to blank a zero hour-tens digit
//            (code 15).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan #(
    parameter int SCAN_DIV    = 1000,
    parameter int BLINK_TICKS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] digits,
    input  logic        edit_mode,
    input  logic [2:0]  edit_sel,
    output logic [2:0]  num,
    output logic [3:0]  d1,
    output logic        flash,
    output logic [5:0]  an
);

    localparam int C_PRE_W = $clog2(SCAN_DIV);
    localparam int C_BLK_W = $clog2(BLINK_TICKS + 1);

    logic [C_PRE_W-1:0] r_pre;
    logic [C_BLK_W-1:0] r_bcnt;
    logic               r_phase;
    logic [23:0]        r_snap;
    logic [2:0]         r_prev_sel;
    logic               r_prev_mode;

    logic               w_tick;
    logic               w_move;
    logic [2:0]         w_num_next;
    logic [3:0]         w_nib;
    logic [3:0]         w_code;
    logic               w_flash;

    assign w_tick     = (r_pre == C_PRE_W'(SCAN_DIV - 1));
    assign w_num_next = (num == 3'd5) ? 3'd0 : num + 3'd1;
    // A new cursor position, or a fresh entry into edit mode, restarts the blink
    assign w_move     = (edit_sel != r_prev_sel) | (edit_mode & ~r_prev_mode);
    // The restarted blink always begins in the visible phase
    assign w_flash    = edit_mode & (edit_sel == w_num_next) & r_phase & ~w_move;

    // Select the nibble for the next slot: fresh bus at frame start, snapshot otherwise
    always_comb begin
        w_nib = r_snap[{w_num_next, 2'b00} +: 4];
        if (num == 3'd5) begin
            w_nib = digits[3:0];
        end
    end

    // Map the raw nibble to a display code (dash for non-BCD, optional blank)
    always_comb begin
        w_code = (w_nib > 4'd9) ? 4'd12 : w_nib;
`ifdef LEADING_ZERO_BLANK_EN
        if ((w_num_next == 3'd5) && (w_nib == 4'd0)) begin
            w_code = 4'd15;
        end
`else
        w_code = w_code;
`endif
    end

    // Prescaler that sets the length of each digit slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + C_PRE_W'(1);
        end
    end

    // Registered scan outputs, which all advance together on each tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num   <= 3'd0;
            d1    <= 4'd0;
            flash <= 1'b0;
            an    <= 6'b000001;
        end else if (w_tick) begin
            num   <= w_num_next;
            d1    <= w_code;
            flash <= w_flash;
            an    <= 6'd1 << w_num_next;
        end
    end

    // Frame snapshot, captured on the tick where the scan wraps to position 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap <= 24'd0;
        end else if (w_tick && (num == 3'd5)) begin
            r_snap <= digits;
        end
    end

    // Blink timing counts ticks; a cursor move takes priority over the phase wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_move) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            if (r_bcnt == C_BLK_W'(BLINK_TICKS - 1)) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt  <= r_bcnt + C_BLK_W'(1);
            end
        end
    end

    // Previous edit controls, used to detect cursor moves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_sel  <= 3'd7;
            r_prev_mode <= 1'b0;
        end else begin
            r_prev_sel  <= edit_sel;
            r_prev_mode <= edit_mode;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_scan.sv
// ============================================================================
// Module   : tb_display_scan
// Function : Self-checking bench for display_scan, using directed and random
//            stimulus. The reference model derives every output from tick
//            counts and from the number of ticks since the last cursor move.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scan;

    localparam int SD = 4;
    localparam int BT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] digits = 24'd0;
    logic        edit_mode = 1'b0;
    logic [2:0]  edit_sel = 3'd7;
    logic [2:0]  num;
    logic [3:0]  d1;
    logic        flash;
    logic [5:0]  an;

    display_scan #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
        .clk       (clk),
        .rst       (rst),
        .digits    (digits),
        .edit_mode (edit_mode),
        .edit_sel  (edit_sel),
        .num       (num),
        .d1        (d1),
        .flash     (flash),
        .an        (an)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int          m_cyc;       // edges since reset
    int          m_tsm;       // ticks since last cursor move
    int          m_num;
    int          m_d1;
    int          m_flash;
    int          m_an;
    int          m_prev_sel;
    bit          m_prev_mode;
    logic [23:0] m_snap;

    task automatic model_reset();
        m_cyc = 0; m_tsm = 0; m_num = 0; m_d1 = 0; m_flash = 0; m_an = 1;
        m_prev_sel = 7; m_prev_mode = 1'b0; m_snap = 24'd0;
    endtask

    function automatic int code_of(int nib, int pos);
        if (nib > 9) return 12;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos == 5 && nib == 0) return 15;
`endif
        return nib;
    endfunction

    task automatic model_edge();
        bit tick, move;
        int nn, ph, nib;
        if (rst) begin
            model_reset();
            return;
        end
        tick = ((m_cyc % SD) == SD - 1);
        move = (int'(edit_sel) != m_prev_sel) || (edit_mode && !m_prev_mode);
        if (tick) begin
            nn = (m_num + 1) % 6;
            ph = move ? 0 : ((m_tsm / BT) % 2);
            if (m_num == 5) begin
                m_snap = digits;
                nib = int'(digits[3:0]);
            end else begin
                nib = int'((m_snap >> (4 * nn)) & 24'hF);
            end
            m_d1    = code_of(nib, nn);
            m_flash = (edit_mode && int'(edit_sel) == nn && ph == 1) ? 1 : 0;
            m_an    = 1 << nn;
            m_num   = nn;
        end
        if (move) m_tsm = 0;
        else if (tick) m_tsm = m_tsm + 1;
        m_prev_sel  = int'(edit_sel);
        m_prev_mode = edit_mode;
        m_cyc = m_cyc + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("num",   32'(num),   32'(m_num));
        check("d1",    32'(d1),    32'(m_d1));
        check("flash", 32'(flash), 32'(m_flash));
        check("an",    32'(an),    32'(m_an));
    endtask

    // One clock: model and DUT advance together, outputs checked 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_all();

        // Basic scan with a constant digit pattern
        digits = 24'h123456;
        rst = 1'b0;
        repeat (30) step();

        // Change digits mid-frame; they become visible only from the next frame
        for (int i = 0; i < 40 && m_num != 2; i++) step();
        digits = 24'h000000;
        repeat (30) step();

        // Non-BCD nibble at position 3
        digits = 24'h00B000;
        repeat (30) step();

        // Blink on position 2
        digits = 24'h123456;
        edit_mode = 1'b1;
        edit_sel = 3'd2;
        repeat (90) step();

        // Move the cursor while in blink phase 1
        for (int i = 0; i < 100 && ((m_tsm / BT) % 2) != 1; i++) step();
        edit_sel = 3'd4;
        repeat (50) step();

        // No digit selected
        edit_sel = 3'd7;
        repeat (30) step();

        // Zero hour-tens digit
        digits = 24'h012345;
        repeat (30) step();

        // Asynchronous reset in the middle of a frame
        for (int i = 0; i < 40 && m_num != 3; i++) step();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        step();
        rst = 1'b0;
        repeat (30) step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) digits = 24'($urandom);
            if ($urandom_range(0, 19) == 0) edit_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) edit_mode = ~edit_mode;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
